// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback,
// with load priority, bounded ALU starvation and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Hold,
  input  logic              AluValid,
  input  logic [4:0]        AluAddr,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              MemValid,
  input  logic [4:0]        MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemReady,
  input  logic              IssueValid,
  input  logic [4:0]        IssueAddr,
  output logic [31:0]       BusyMask,
  output logic              we,
  output logic [4:0]        WriteAddr,
  output logic [DATA_W-1:0] WriteData
);

  typedef enum logic {MEM_FIRST, ALU_FIRST} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  logic [3:0]        starve_cnt;
  logic [3:0]        cnt_next;
  logic              grant;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_real;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;
  logic [31:0]       busy_next;

  // Grant selection: purely from Valids, Hold, rst and the FSM state.
  always_comb begin
    AluReady = 1'b0;
    MemReady = 1'b0;
    if (!rst && !Hold) begin
      if (state == MEM_FIRST) begin
        if (MemValid)      MemReady = 1'b1;
        else if (AluValid) AluReady = 1'b1;
      end else begin
        if (AluValid)      AluReady = 1'b1;
        else if (MemValid) MemReady = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_next = starve_cnt;
    if (!AluValid || AluReady)
      cnt_next = 4'd0;
    else if (state == MEM_FIRST && starve_cnt != STARVE_LIM)
      cnt_next = starve_cnt + 4'd1;
  end

  always_comb begin
    grant   = AluReady | MemReady;
    wr_addr = MemReady ? MemAddr : AluAddr;
    wr_data = MemReady ? MemData : AluData;
    wr_real = grant && (wr_addr != 5'd0);
    set_vec = (IssueValid && IssueAddr != 5'd0) ? (32'd1 << IssueAddr) : 32'd0;
    clr_vec = wr_real ? (32'd1 << wr_addr) : 32'd0;
    // A set on the same address as a clear wins: a newer writer is pending.
    busy_next    = (BusyMask & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
  end

  // Registered write port, scoreboard and arbiter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MEM_FIRST;
      starve_cnt <= 4'd0;
      BusyMask   <= 32'd0;
      we         <= 1'b0;
      WriteAddr  <= 5'd0;
      WriteData  <= '0;
    end else begin
      BusyMask <= busy_next;
      we       <= wr_real;
      if (wr_real) begin
        WriteAddr <= wr_addr;
        WriteData <= wr_data;
      end
      if (!Hold) begin
        starve_cnt <= cnt_next;
        if (state == MEM_FIRST && cnt_next == STARVE_LIM)
          state <= ALU_FIRST;
        else if (state == ALU_FIRST && AluReady)
          state <= MEM_FIRST;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between the ALU writeback path and the load (memory) writeback path, and keeps a pending-write scoreboard for hazard detection. Sits between the execute/memory stages and the `Registers` block and drives its `we`/`WriteAddr`/`WriteData` directly. Loads have priority, and a starvation counter bounds ALU wait time. Writes are registered, so the register file sees one clean write per cycle.

## Interface
- `DATA_W`, default 32: writeback data width.
- `STARVE_MAX`, default 3: number of consecutive denied ALU cycles before the ALU is forced to win; legal range 1..15.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Hold` in 1: when high, no grants are issued and state is frozen, except that scoreboard sets still apply.
- `AluValid` in 1: ALU writeback request.
- `AluAddr` in 5: ALU destination register.
- `AluData` in DATA_W: ALU result.
- `AluReady` out 1: grant to ALU, combinational.
- `MemValid` in 1: load writeback request.
- `MemAddr` in 5: load destination register.
- `MemData` in DATA_W: load data.
- `MemReady` out 1: grant to the load path, combinational.
- `IssueValid` in 1: an instruction with destination `IssueAddr` was issued.
- `IssueAddr` in 5: destination register to mark pending.
- `BusyMask` out 32: bit n high means register n has a write pending.
- `we` out 1: register-file write enable, registered.
- `WriteAddr` out 5: register-file write address, registered.
- `WriteData` out DATA_W: register-file write data, registered.

## Operation
Arbiter FSM has two states, `MEM_FIRST` (the reset state) and `ALU_FIRST`.
- `Hold`=1: `AluReady`=`MemReady`=0.
- In `MEM_FIRST`:
  - `MemValid` gets the grant; otherwise `AluValid` gets it.
  - If `AluValid` and not granted, `starve_cnt`++.
  - When `starve_cnt` == `STARVE_MAX` at a clock edge, go to `ALU_FIRST`.
- In `ALU_FIRST`:
  - `AluValid` gets the grant; otherwise `MemValid` gets it.
  - On an ALU grant, go to `MEM_FIRST`.
- Any ALU grant clears `starve_cnt` to 0. A cycle with `AluValid`=0 also clears it.
- `starve_cnt` saturates at `STARVE_MAX` and is 4 bits wide.
- At most one Ready is high per cycle.
- Ready depends only on the Valids, `Hold`, and the FSM state, never on the Ready outputs.

Handshake:
- A requester holds Valid, Addr, and Data stable until the cycle in which Ready=1.
- The transfer completes in that cycle.
- Valid may drop only after the transfer.

Write port:
- A granted request with Addr≠0 registers `we`=1, Addr, and Data.
- A grant to Addr=0 is consumed: Ready=1 but `we` stays 0 (x0 is discarded).
- With no grant, `we`=0. `WriteAddr`/`WriteData` hold their last values.

Scoreboard:
- `IssueValid` with `IssueAddr`≠0 sets `BusyMask[IssueAddr]`.
- A granted write to Addr≠0 clears `BusyMask[Addr]`.
- If a set and a clear hit the same address in the same cycle, the set wins (a newer writer is pending).
- `BusyMask[0]` is constant 0.
- A write to a register that is not busy is legal and leaves it 0.

Reset:
- All of the following go to 0 on the next edge, regardless of in-flight requests: `we`, `WriteAddr`, `WriteData`, `BusyMask`, `starve_cnt`. The FSM goes to `MEM_FIRST`.
- While `rst`=1, `AluReady`=`MemReady`=0.
- Requests pending at reset are dropped. Requesters re-present them after reset.

## Timing
- Grant in cycle t leads to `we`/`WriteAddr`/`WriteData` valid in cycle t+1 for exactly one cycle.
- The busy bit clears on the edge ending cycle t. In t+1 the bit is 0 and the register-file write-forward path supplies the data.
- Throughput is one write per cycle with back-to-back grants.
- Worst-case ALU wait is `STARVE_MAX`+1 cycles of continuous load traffic, excluding `Hold` cycles.
- `Hold` cycles do not increment `starve_cnt`.
- A request that finds both Ready low waits with no timeout.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both Valids high → Readys 0, and `we`=0, `WriteAddr`=0, `WriteData`=0, `BusyMask`=0 on the edge after `rst` rises. The first grant after release goes to Mem.
- **Single ALU write:** `AluValid`, `AluAddr`=5, `AluData`=0xDEADBEEF → `AluReady`=1 in cycle t; `we`=1, `WriteAddr`=5, `WriteData`=0xDEADBEEF in t+1; `we`=0 in t+2.
- **Starvation:** both Valids held high, `STARVE_MAX`=3 → grant sequence Mem, Mem, Mem, Alu, Mem, Mem, Mem, Alu; `starve_cnt` reads 3 before each Alu grant.
- **Scoreboard:**
  - `IssueValid`/`IssueAddr`=7 → `BusyMask`=0x80.
  - Then Mem write to 7 → bit 7 is 0 in the cycle `we`=1.
  - Issue to 7 in the same cycle as a granted write to 7 → bit stays 1.
- **x0:** `MemValid`, `MemAddr`=0, `MemData`=0x1234 → `MemReady`=1, `we` stays 0. `IssueAddr`=0 → `BusyMask` unchanged.
- **Hold and mid-run reset:** `Hold`=1 for 4 cycles with `AluValid` high → no Ready, `starve_cnt` unchanged. Then `rst` pulsed while `BusyMask`=0x0000_00F0 → mask 0, and no write occurs on the edge after `rst`.
